// File: rtl/ruler_ctrl_if.sv
// Handshake bundle between the ruler controller and its environment (enable, feedback, strobe/dir, error).
interface ruler_ctrl_if #(
  parameter int unsigned RULER_WIDTH = 8
);
  logic                   en_i;
  logic [RULER_WIDTH-1:0] ruler_i;
  logic                   stb_o;
  logic                   dir_o;
  logic                   err_o;

  modport master (
    output en_i,
    output ruler_i,
    input  stb_o,
    input  dir_o,
    input  err_o
  );

  modport slave (
    input  en_i,
    input  ruler_i,
    output stb_o,
    output dir_o,
    output err_o
  );
endinterface

// File: rtl/ruler_ctrl.sv
// Bouncing-LED ruler controller: prescaled step strobes, corner reversal, sticky one-hot fault.
// Optional RULER_CTRL_BOUNCE_CNT_EN adds a saturating 16-bit reversal counter on bounce_o.
module ruler_ctrl #(
  parameter int unsigned RULER_WIDTH = 8,
  parameter int unsigned TRIGGER_CNT = 50000000,
  parameter int unsigned CNT_WIDTH   = 26
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ruler_ctrl_if.slave  bus
`ifdef RULER_CTRL_BOUNCE_CNT_EN
  ,
  output logic [15:0]  bounce_o
`endif
);

  typedef enum logic [1:0] {StIdle, StLeft, StRight, StFault} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TRIGGER_CNT - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stb_q, stb_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;
  logic                   one_hot;
  logic                   tick;
  logic [RULER_WIDTH-1:0] ruler;

  assign ruler   = bus.ruler_i;
  assign one_hot = (ruler != '0) && ((ruler & (ruler - RULER_WIDTH'(1))) == '0);
  assign tick    = bus.en_i && (cnt_q == CntMax) &&
                   ((state_q == StLeft) || (state_q == StRight));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.en_i) begin
          state_d = StLeft;
          cnt_d   = '0;
        end
      end
      StLeft, StRight: begin
        if (tick) begin
          cnt_d = '0;
          // A corrupt sample wins over any corner decision.
          if (!one_hot) begin
            state_d = StFault;
            err_d   = 1'b1;
          end else if ((state_q == StLeft) && ruler[RULER_WIDTH-1]) begin
            state_d = StRight;
            dir_d   = 1'b1;
            stb_d   = 1'b1;
          end else if ((state_q == StRight) && ruler[0]) begin
            state_d = StLeft;
            dir_d   = 1'b0;
            stb_d   = 1'b1;
          end else begin
            stb_d   = 1'b1;
          end
        end else if (bus.en_i) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StFault: begin
        err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign bus.stb_o = stb_q;
  assign bus.dir_o = dir_q;
  assign bus.err_o = err_q;

`ifdef RULER_CTRL_BOUNCE_CNT_EN
  logic [15:0] bounce_q, bounce_d;

  always_comb begin
    bounce_d = bounce_q;
    if (stb_d && (dir_d != dir_q) && (bounce_q != 16'hFFFF)) begin
      bounce_d = bounce_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bounce_q <= '0;
    end else begin
      bounce_q <= bounce_d;
    end
  end

  assign bounce_o = bounce_q;
`endif

endmodule
